// File: rtl/hand_dealer.sv
// hand_dealer: deals counter-generated cards into alternating player/dealer slots and scores both hands
module hand_dealer #(
  parameter int unsigned CARD_MAX = 13,
  parameter int unsigned FACE_MIN = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        deal,
  input  logic        clear,
  output logic [3:0]  card_value,
  output logic [11:0] player_cards,
  output logic [11:0] dealer_cards,
  output logic [3:0]  player_score,
  output logic [3:0]  dealer_score,
  output logic [2:0]  next_slot,
  output logic        done
);
  typedef enum logic [2:0] {S_P1, S_D1, S_P2, S_D2, S_P3, S_D3, S_DONE} state_t;
  state_t state, stateNext;
  logic dealQ, load;
  logic [3:0] slots [6];
  function automatic logic [3:0] points(input logic [3:0] v);
    return v >= 4'(FACE_MIN) ? 4'd0 : v;
  endfunction
  function automatic logic [3:0] score(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [4:0] s;
    s = 5'(points(a)) + 5'(points(b)) + 5'(points(c));
    s = s >= 5'd20 ? s - 5'd20 : s >= 5'd10 ? s - 5'd10 : s;
    return s[3:0];
  endfunction
  always_comb begin
    load = deal & ~dealQ & ~clear & (state != S_DONE);
    stateNext = clear ? S_P1 : load ? state_t'(state + 3'd1) : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      card_value <= 4'd1;
      dealQ <= 1'b0;
      state <= S_P1;
      slots <= '{default: 4'd0};
    end else begin
      card_value <= card_value == 4'(CARD_MAX) ? 4'd1 : card_value + 4'd1;
      dealQ <= deal;
      state <= stateNext;
      for (int i = 0; i < 6; i++)
        if (clear) slots[i] <= 4'd0;
        else if (load && state == state_t'(3'(i))) slots[i] <= card_value;
    end
  end
  // slot order follows the deal order P1,D1,P2,D2,P3,D3
  assign player_cards = {slots[4], slots[2], slots[0]};
  assign dealer_cards = {slots[5], slots[3], slots[1]};
  assign player_score = score(slots[0], slots[2], slots[4]);
  assign dealer_score = score(slots[1], slots[3], slots[5]);
  assign next_slot = state;
  assign done = state == S_DONE;
endmodule

// File: tb/tb_hand_dealer.sv
// tb_hand_dealer: directed table-driven checks of dealing order, scoring, clear and reset
module tb_hand_dealer;
  logic clock = 0, reset = 1, deal = 0, clear = 0;
  logic [3:0] card_value, player_score, dealer_score;
  logic [11:0] player_cards, dealer_cards;
  logic [2:0] next_slot;
  logic done;
  int checks = 0, errors = 0;

  hand_dealer dut (
    .clock(clock), .reset(reset), .deal(deal), .clear(clear),
    .card_value(card_value), .player_cards(player_cards), .dealer_cards(dealer_cards),
    .player_score(player_score), .dealer_score(dealer_score),
    .next_slot(next_slot), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  card;
    logic [11:0] expPlayer;
    logic [11:0] expDealer;
    logic [3:0]  expPs;
    logic [3:0]  expDs;
    logic [2:0]  expNext;
    logic        expDone;
  } vec_t;
  vec_t hand [6];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkAll(input string name, input logic [11:0] p, input logic [11:0] d,
                        input logic [3:0] ps, input logic [3:0] ds, input logic [2:0] ns, input logic dn);
    chk({name, ".player"}, player_cards, p);
    chk({name, ".dealer"}, dealer_cards, d);
    chk({name, ".pscore"}, 12'(player_score), 12'(ps));
    chk({name, ".dscore"}, 12'(dealer_score), 12'(ds));
    chk({name, ".next"}, 12'(next_slot), 12'(ns));
    chk({name, ".done"}, 12'(done), 12'(dn));
  endtask

  task automatic waitCard(input logic [3:0] v);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (card_value !== v && n < 40);
    if (card_value !== v) begin
      checks++;
      errors++;
      $display("FAIL waitCard: got %0d expected %0d", card_value, v);
    end
  endtask

  task automatic dealOne(input logic [3:0] v);
    waitCard(v);
    deal = 1;
    @(negedge clock);
    deal = 0;
  endtask

  task automatic doClear();
    @(negedge clock);
    clear = 1;
    @(negedge clock);
    clear = 0;
  endtask

  initial begin
    logic [3:0] expCard;
    hand[0] = '{4'd7,  12'h007, 12'h000, 4'd7, 4'd0, 3'd1, 1'b0};
    hand[1] = '{4'd13, 12'h007, 12'h00D, 4'd7, 4'd0, 3'd2, 1'b0};
    hand[2] = '{4'd6,  12'h067, 12'h00D, 4'd3, 4'd0, 3'd3, 1'b0};
    hand[3] = '{4'd12, 12'h067, 12'h0CD, 4'd3, 4'd0, 3'd4, 1'b0};
    hand[4] = '{4'd3,  12'h367, 12'h0CD, 4'd6, 4'd0, 3'd5, 1'b0};
    hand[5] = '{4'd1,  12'h367, 12'h1CD, 4'd6, 4'd1, 3'd6, 1'b1};

    // reset state and counter wrap
    @(negedge clock);
    @(negedge clock);
    chkAll("reset", 12'h0, 12'h0, 4'd0, 4'd0, 3'd0, 1'b0);
    chk("reset.card", 12'(card_value), 12'd1);
    reset = 0;
    expCard = 4'd1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      expCard = expCard == 4'd13 ? 4'd1 : expCard + 4'd1;
      chk("counter", 12'(card_value), 12'(expCard));
    end

    // single held deal loads exactly one card
    waitCard(4'd7);
    deal = 1;
    @(negedge clock);
    chkAll("single1", 12'h007, 12'h0, 4'd7, 4'd0, 3'd1, 1'b0);
    repeat (19) @(negedge clock);
    chkAll("single20", 12'h007, 12'h0, 4'd7, 4'd0, 3'd1, 1'b0);
    deal = 0;

    // full hand from the table
    doClear();
    chkAll("clear", 12'h0, 12'h0, 4'd0, 4'd0, 3'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      waitCard(hand[i].card);
      deal = 1;
      @(negedge clock);
      chkAll($sformatf("hand%0d", i), hand[i].expPlayer, hand[i].expDealer,
             hand[i].expPs, hand[i].expDs, hand[i].expNext, hand[i].expDone);
      deal = 0;
    end
    dealOne(4'd5);
    chkAll("seventh", 12'h367, 12'h1CD, 4'd6, 4'd1, 3'd6, 1'b1);

    // clear collides with a deal edge; held deal must not deal afterwards
    doClear();
    dealOne(4'd2);
    dealOne(4'd3);
    dealOne(4'd4);
    chkAll("three", 12'h042, 12'h003, 4'd6, 4'd3, 3'd3, 1'b0);
    clear = 1;
    deal = 1;
    @(negedge clock);
    chkAll("collide", 12'h0, 12'h0, 4'd0, 4'd0, 3'd0, 1'b0);
    clear = 0;
    @(negedge clock);
    chkAll("collideHold", 12'h0, 12'h0, 4'd0, 4'd0, 3'd0, 1'b0);
    deal = 0;

    // reset mid-hand with a rising deal
    dealOne(4'd8);
    dealOne(4'd9);
    dealOne(4'd10);
    dealOne(4'd11);
    chk("four.next", 12'(next_slot), 12'd4);
    reset = 1;
    deal = 1;
    @(negedge clock);
    chkAll("midReset", 12'h0, 12'h0, 4'd0, 4'd0, 3'd0, 1'b0);
    chk("midReset.card", 12'(card_value), 12'd1);
    reset = 0;
    deal = 0;
    @(negedge clock);
    deal = 1;
    @(negedge clock);
    chkAll("afterReset", 12'h002, 12'h0, 4'd2, 4'd0, 3'd1, 1'b0);
    deal = 0;

    // face-card scoring and mod-10 wrap
    doClear();
    dealOne(4'd10);
    dealOne(4'd5);
    dealOne(4'd11);
    dealOne(4'd5);
    dealOne(4'd9);
    chkAll("face", 12'h9B_A, 12'h055, 4'd9, 4'd0, 3'd5, 1'b0);
    dealOne(4'd8);
    chkAll("faceD3", 12'h9BA, 12'h855, 4'd9, 4'd8, 3'd6, 1'b1);
    doClear();
    dealOne(4'd9);
    dealOne(4'd1);
    dealOne(4'd9);
    dealOne(4'd13);
    dealOne(4'd9);
    chkAll("wrap27", 12'h999, 12'h0D1, 4'd7, 4'd1, 3'd5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hand_dealer.md
Name: hand_dealer

Overview:
Card-dealing stage that sits directly upstream of card7seg. It generates card values 1..13 from a free-running counter and deals them on a deal request into three player slots and three dealer slots, in fixed alternating order. It also reports the baccarat score of each hand. Each 4-bit slot output drives one card7seg instance. Value 0 means an empty slot, which card7seg shows as blank.

Parameters:
CARD_MAX, 13, highest card value. The counter wraps from CARD_MAX back to 1.
FACE_MIN, 10, card values at or above this score 0 points.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
deal  input  1  deal request, level; one card per 0->1 transition
clear  input  1  synchronous hand clear; empties all slots, counter keeps running
card_value  output  4  current counter value, i.e. the card that a deal taken this cycle will load
player_cards  output  12  [3:0]=P1, [7:4]=P2, [11:8]=P3; 0 = empty
dealer_cards  output  12  [3:0]=D1, [7:4]=D2, [11:8]=D3; 0 = empty
player_score  output  4  (sum of player slot points) mod 10
dealer_score  output  4  (sum of dealer slot points) mod 10
next_slot  output  3  0..5 = P1,D1,P2,D2,P3,D3 is next; 6 = hand full
done  output  1  high when all six slots are loaded

Behaviour:
- Reset (synchronous, active-high):
  - all slots 0; counter 1; deal_q 0; state S_P1.
  - done 0, next_slot 0, both scores 0.
  - Reset overrides clear and deal.
- Reset mid-operation: same result in the following cycle regardless of state. No partial deal survives.
- Counter:
  - increments every clock when not in reset; after CARD_MAX it goes to 1.
  - never holds 0, 14 or 15.
  - card_value is the registered counter output.
- Edge detect:
  - deal_q registers deal every cycle (including on clear cycles).
  - deal_edge = deal & ~deal_q.
  - Holding deal high deals exactly one card.
- Deal:
  - when deal_edge=1, clear=0 and state is not S_DONE, the slot selected by the state is loaded with card_value as sampled on that edge (the pre-increment value).
  - The slot output changes one cycle after deal rises.
  - The state then advances one step.
- State sequence: S_P1 -> S_D1 -> S_P2 -> S_D2 -> S_P3 -> S_D3 -> S_DONE.
  - next_slot encodes the state as 0..6.
  - done = (state == S_DONE).
- S_DONE: deal edges are ignored and slots hold. Only clear or reset leaves it.
- Clear: all slots go to 0 and state goes to S_P1 on the next edge. The counter is unaffected.
- clear and deal_edge in the same cycle: clear wins, no card is loaded. deal_q still updates, so a held deal does not deal on the next cycle.
- Scoring:
  - combinational from the slot registers.
  - points(v) = 0 if v == 0 or v >= FACE_MIN, else v.
  - score = sum of the 3 points mod 10 (sum 0..27; use a 5-bit intermediate).
  - Scores are valid in the same cycle the slots update.
- No other outputs change on a deal except the targeted slot, the scores, next_slot and done.

Test Plan:
1. Counter wrap: assert reset 2 cycles, release, then observe card_value -> 1,2,...,13,1,2 on consecutive cycles; never 0 or >13.
2. Single deal: raise deal in the cycle where card_value=7 and hold it high 20 cycles -> player_cards[3:0]=7 from the next cycle; all other slots stay 0; next_slot=1; no further loads.
3. Full hand: deal pulses at card_value = 7,13,6,12,3,1 -> player_cards=12'h367, dealer_cards=12'h1CD. Scores step as follows:
   - player_score 7 -> 3 (after P2) -> 6 (after P3).
   - dealer_score 0 -> 0 (after D2) -> 1 (after D3).
   - done=1, next_slot=6.
   - A 7th deal pulse changes nothing.
4. Clear collision: after 3 cards are dealt, assert clear and a deal edge in the same cycle -> next cycle all slots 0, scores 0, next_slot 0. Keep deal high one more cycle with clear low -> no card is loaded.
5. Reset mid-hand: after 4 cards, pulse reset with deal rising in the same cycle -> slots 0, card_value=1, next_slot 0, done 0. A fresh deal then loads P1.
6. Face-card scoring: P1=10, P2=11, P3=9 -> player_score=9. D1=5, D2=5 -> dealer_score=0 (mod-10 wrap).
